// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers (reduction polynomial 0x11B).
// S-boxes are computed as GF inverse plus affine map rather than stored as tables.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [7:0]             aes_byte_t;
  typedef logic [31:0]            aes_word_t;
  typedef logic [AES_BLOCK_W-1:0] aes_state_t;

  localparam logic AES_ENC = 1'b0;
  localparam logic AES_DEC = 1'b1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic aes_byte_t xtime(input aes_byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t gmul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 for nonzero a, and maps 0 to 0 as the S-box requires.
  function automatic aes_byte_t gf_inv(input aes_byte_t a);
    aes_byte_t r;
    aes_byte_t p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic aes_byte_t sbox(input aes_byte_t a);
    aes_byte_t s;
    s = gf_inv(a);
    return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_byte_t inv_sbox(input aes_byte_t a);
    aes_byte_t t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// Combinational AES round: encrypt SB/SR/MC/ARK or decrypt ISR/ISB/ARK/IMC.
// Mixing stage is bypassed when is_last is set; byte 0 sits in bits [127:120].
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   mode,
  input  logic                   is_last,
  output logic [AES_BLOCK_W-1:0] state_out
);

  aes_byte_t b  [16];
  aes_byte_t kb [16];
  aes_byte_t t  [16];
  aes_byte_t y  [16];
  aes_byte_t mi [16];
  aes_byte_t mc [16];

  always_comb begin
    state_out = '0;
    for (int k = 0; k < 16; k++) begin
      b[k]  = state_in[127-8*k -: 8];
      kb[k] = round_key[127-8*k -: 8];
    end
    // Byte k is row k%4, column k/4; rows rotate left (enc) or right (dec) by row index.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (mode == AES_ENC) t[r+4*c] = sbox(b[r+4*((c+r)%4)]);
        else                 t[r+4*c] = inv_sbox(b[r+4*((c+4-r)%4)]);
      end
    end
    for (int k = 0; k < 16; k++) begin
      y[k]  = t[k] ^ kb[k];
      mi[k] = (mode == AES_ENC) ? t[k] : y[k];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (mode == AES_ENC)
          mc[r+4*c] = gmul(mi[r+4*c], 8'h02) ^ gmul(mi[(r+1)%4+4*c], 8'h03)
                    ^ mi[(r+2)%4+4*c] ^ mi[(r+3)%4+4*c];
        else
          mc[r+4*c] = gmul(mi[r+4*c], 8'h0e) ^ gmul(mi[(r+1)%4+4*c], 8'h0b)
                    ^ gmul(mi[(r+2)%4+4*c], 8'h0d) ^ gmul(mi[(r+3)%4+4*c], 8'h09);
      end
    end
    for (int k = 0; k < 16; k++) begin
      if (mode == AES_ENC) state_out[127-8*k -: 8] = (is_last ? t[k] : mc[k]) ^ kb[k];
      else                 state_out[127-8*k -: 8] = is_last ? y[k] : mc[k];
    end
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 enc/dec, one round per clk, out_valid NR cycles after accept.
// Result held in DONE until out_ready; AES_KEY_LATCH_EN copies round_keys on accept.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter  int NK = 4,
  localparam int NR = NK + 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [AES_BLOCK_W-1:0]  in_block,
  input  logic [128*(NR+1)-1:0]   round_keys,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AES_BLOCK_W-1:0]  out_block,
  output logic                    busy
);

  localparam logic [3:0] NR_C = 4'(NR);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_nk_check
    $error("aes_iter_core: NK must be 4, 6 or 8");
  end

  logic [1:0]            fsm;
  aes_state_t            st;
  aes_state_t            st_nxt;
  logic [3:0]            rnd;
  logic [3:0]            key_idx;
  logic                  mode_q;
  logic                  accept;
  logic                  last_rnd;
  logic [127:0]          init_key;
  logic [128*(NR+1)-1:0] key_src;
  logic [127:0]          rk_arr [NR+1];

`ifdef AES_KEY_LATCH_EN
  logic [128*(NR+1)-1:0] key_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       key_q <= '0;
    else if (accept) key_q <= round_keys;
  end

  assign key_src = key_q;
`else
  assign key_src = round_keys;
`endif

  for (genvar i = 0; i <= NR; i++) begin : g_rk
    assign rk_arr[i] = key_src[128*i +: 128];
  end

  assign in_ready  = (fsm == IDLE) || (fsm == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (fsm == ROUND);
  assign out_valid = (fsm == DONE);
  assign out_block = st;
  assign last_rnd  = (rnd == NR_C);
  assign key_idx   = (mode_q == AES_DEC) ? NR_C - rnd : rnd;
  // Initial whitening always comes straight from the port: the latched copy is not loaded yet.
  assign init_key  = (in_mode == AES_DEC) ? round_keys[128*NR +: 128] : round_keys[127:0];

  aes_round_unit u_round (
    .state_in  (st),
    .round_key (rk_arr[key_idx]),
    .mode      (mode_q),
    .is_last   (last_rnd),
    .state_out (st_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm    <= IDLE;
      st     <= '0;
      rnd    <= '0;
      mode_q <= AES_ENC;
    end else if (accept) begin
      st     <= in_block ^ init_key;
      mode_q <= in_mode;
      rnd    <= 4'd1;
      fsm    <= ROUND;
    end else if (fsm == ROUND) begin
      st  <= st_nxt;
      rnd <= rnd + 4'd1;
      if (last_rnd) fsm <= DONE;
    end else if (fsm == DONE && out_ready) begin
      fsm <= IDLE;
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core at NK=4/6/8 against a table-driven FIPS-197 model.
module tb_aes_iter_core;

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  logic clk;
  logic reset;
  logic [2:0] in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  logic [2:0][127:0]  in_block, out_block;
  logic [2:0][1919:0] rk;

  int n_tests = 0;
  int n_fail  = 0;

  int sbox_t [256];
  int isbox_t[256];
  int exp_t  [256];
  int log_t  [256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_iter_core #(.NK(4 + 2*g)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_mode    (in_mode[g]),
      .in_block   (in_block[g]),
      .round_keys (rk[g][128*(11+2*g)-1:0]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_block  (out_block[g]),
      .busy       (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void build_tables();
    int x, inv, v;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x ^ (((x << 1) ^ (((x & 128) != 0) ? 283 : 0)) & 255);
    end
    exp_t[255] = exp_t[0];
    log_t[0] = 0;
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 0 : exp_t[(255 - log_t[a]) % 255];
      v = inv ^ 99;
      for (int k = 1; k <= 4; k++) v = v ^ (((inv << k) | (inv >> (8 - k))) & 255);
      sbox_t[a]  = v;
      isbox_t[v] = a;
    end
  endfunction

  function automatic int gf_mul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  function automatic logic [31:0] mix_col(input int a0, a1, a2, a3, input logic inv);
    int c0, c1, c2, c3;
    int a[4];
    logic [31:0] r;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    c0 = inv ? 14 : 2; c1 = inv ? 11 : 3; c2 = inv ? 13 : 1; c3 = inv ? 9 : 1;
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = 8'(gf_mul(a[i], c0) ^ gf_mul(a[(i+1)%4], c1)
                         ^ gf_mul(a[(i+2)%4], c2) ^ gf_mul(a[(i+3)%4], c3));
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(sbox_t[int'(w[8*i +: 8])]);
    return r;
  endfunction

  function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
    logic [31:0] w[60];
    logic [31:0] temp;
    logic [1919:0] res;
    int rcon;
    rcon = 1;
    res = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {8'(rcon), 24'h0};
        rcon = ((rcon << 1) ^ (((rcon & 128) != 0) ? 283 : 0)) & 255;
      end else if (nk > 6 && i % nk == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r < nk + 7; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] ref_aes(input int nk, input logic [1919:0] rks,
                                           input logic dec, input logic [127:0] blk);
    int s[16];
    int t[16];
    int nr;
    logic [31:0] m;
    logic [127:0] res;
    nr = nk + 6;
    for (int k = 0; k < 16; k++) s[k] = int'(blk[127-8*k -: 8]);
    if (!dec) begin
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ int'(rks[127-8*k -: 8]);
      for (int r = 1; r <= nr; r++) begin
        for (int k = 0; k < 16; k++) t[k] = sbox_t[s[k]];
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
        if (r < nr)
          for (int c = 0; c < 4; c++) begin
            m = mix_col(s[4*c], s[4*c+1], s[4*c+2], s[4*c+3], 1'b0);
            for (int w = 0; w < 4; w++) s[w+4*c] = int'(m[31-8*w -: 8]);
          end
        for (int k = 0; k < 16; k++) s[k] = s[k] ^ int'(rks[128*r + 127 - 8*k -: 8]);
      end
    end else begin
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ int'(rks[128*nr + 127 - 8*k -: 8]);
      for (int r = nr - 1; r >= 0; r--) begin
        for (int k = 0; k < 16; k++) t[k] = s[k];
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++) s[w+4*c] = isbox_t[t[w+4*((c+4-w)%4)]];
        for (int k = 0; k < 16; k++) s[k] = s[k] ^ int'(rks[128*r + 127 - 8*k -: 8]);
        if (r > 0)
          for (int c = 0; c < 4; c++) begin
            m = mix_col(s[4*c], s[4*c+1], s[4*c+2], s[4*c+3], 1'b1);
            for (int w = 0; w < 4; w++) s[w+4*c] = int'(m[31-8*w -: 8]);
          end
      end
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = 8'(s[k]);
    return res;
  endfunction

  // ---------------- handshake helpers ----------------
  task automatic send(input int j, input logic m, input logic [127:0] blk, input string tag);
    @(negedge clk);
    check({tag, "_rdy"}, 128'(in_ready[j]), 128'(1));
    in_valid[j] = 1'b1;
    in_mode[j]  = m;
    in_block[j] = blk;
    @(negedge clk);
    in_valid[j] = 1'b0;
  endtask

  task automatic wait_result(input int j, input logic [127:0] exp, input string tag);
    int k;
    k = 0;
    while (out_valid[j] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 128'(k), 128'(10 + 2*j));
    check({tag, "_out"}, out_block[j], exp);
  endtask

  task automatic drain(input int j, input string tag);
    out_ready[j] = 1'b1;
    @(negedge clk);
    out_ready[j] = 1'b0;
    check({tag, "_drain"}, 128'(out_valid[j]), 128'(0));
  endtask

  task automatic run_block(input int j, input logic m, input logic [127:0] blk,
                           input logic [127:0] exp, input string tag);
    send(j, m, blk, tag);
    wait_result(j, exp, tag);
    drain(j, tag);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [255:0] key;
    logic [127:0] blk, exp;
    logic m;
    reset = 1'b1;
    in_valid = '0; in_mode = '0; out_ready = '0;
    in_block = '0; rk = '0;
    build_tables();
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("reset_ov%0d", j),   128'(out_valid[j]), 128'(0));
      check($sformatf("reset_busy%0d", j), 128'(busy[j]),      128'(0));
      check($sformatf("reset_rdy%0d", j),  128'(in_ready[j]),  128'(1));
      check($sformatf("reset_blk%0d", j),  out_block[j],       128'(0));
    end
    reset = 1'b0;

    // Known-answer vectors, both directions
    rk[0] = expand(4, KEY_SEQ);
    rk[1] = expand(6, KEY_SEQ);
    rk[2] = expand(8, KEY_SEQ);
    run_block(0, ENC, PT, CT128, "kat128_enc");
    run_block(0, DEC, CT128, PT, "kat128_dec");
    run_block(1, ENC, PT, CT192, "kat192_enc");
    run_block(1, DEC, CT192, PT, "kat192_dec");
    run_block(2, ENC, PT, CT256, "kat256_enc");
    run_block(2, DEC, CT256, PT, "kat256_dec");

    // Random keys/blocks/modes against the model, plus round trip
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < 3; j++) begin
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        blk = {$urandom, $urandom, $urandom, $urandom};
        m = 1'($urandom_range(0, 1));
        rk[j] = expand(4 + 2*j, key);
        exp = ref_aes(4 + 2*j, rk[j], m, blk);
        run_block(j, m, blk, exp, $sformatf("rnd%0d_nk%0d", it, 4 + 2*j));
        run_block(j, ~m, exp, blk, $sformatf("rt%0d_nk%0d", it, 4 + 2*j));
      end
    end

    // Backpressure then back-to-back accept on the draining edge
    rk[0] = expand(4, KEY_SEQ);
    send(0, ENC, PT, "bp");
    wait_result(0, CT128, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold_blk%0d", i), out_block[0], CT128);
      check($sformatf("hold_rdy%0d", i), 128'(in_ready[0]), 128'(0));
    end
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_mode[0]   = DEC;
    in_block[0]  = CT128;
    #1;
    check("b2b_rdy", 128'(in_ready[0]), 128'(1));
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    check("b2b_ov",   128'(out_valid[0]), 128'(0));
    check("b2b_busy", 128'(busy[0]),      128'(1));
    wait_result(0, PT, "b2b");
    drain(0, "b2b");

    // Abort by reset mid-operation (rnd == 5)
    send(0, ENC, PT, "abort");
    repeat (4) @(negedge clk);
    check("abort_busy_pre", 128'(busy[0]), 128'(1));
    reset = 1'b1;
    #1;
    check("abort_ov",   128'(out_valid[0]), 128'(0));
    check("abort_busy", 128'(busy[0]),      128'(0));
    check("abort_rdy",  128'(in_ready[0]),  128'(1));
    @(negedge clk);
    reset = 1'b0;
    run_block(0, ENC, PT, CT128, "post_abort");

`ifdef AES_KEY_LATCH_EN
    rk[0] = expand(4, KEY_SEQ);
    send(0, ENC, PT, "keylatch");
    rk[0] = '0;
    wait_result(0, CT128, "keylatch");
    drain(0, "keylatch");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
